data_mem_responder: RTL

- Responder end of the lw/sw data-transfer interface.
- Accepts one request at a time: opcode, effective word address (rs+rt from the address unit) and store data.
- Services it against an on-chip word-addressed data memory after a fixed, parameterised latency, then returns a single-cycle response (load data or store completion, plus fault flag).
- Sits between the processor's data-transfer path and data storage.

---
 rtl/data_mem_responder_pkg.sv | 20 ++
 rtl/data_mem_array.sv | 37 +++
 rtl/data_mem_responder.sv | 117 +++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-transfer responder: opcodes, FSM states
// and the response record.
package data_mem_responder_pkg;

   localparam logic [5:0] OPC_LW = 6'd8;
   localparam logic [5:0] OPC_SW = 6'd9;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] rdata;
      logic        fault;
   } resp_t;

endpackage

// File: rtl/data_mem_array.sv
// Single-port synchronous word RAM, cleared by reset.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-high; clears every word and the read register
//   we     - write enable; writes wdata to mem[idx]
//   idx    - word index
//   wdata  - write data
//   rdata  - registered read of mem[idx] (read-before-write on the same edge)
module data_mem_array #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] idx,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rdata <= '0;
      end else begin
         if (we) begin
            mem[idx] <= wdata;
         end
         rdata <= mem[idx];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for lw/sw data transfers: accepts one request, services it against
// the on-chip data memory after LATENCY cycles, then strobes a one-cycle
// response carrying load data and a fault flag.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | req_ready=1, waiting for req_valid
//   BUSY  | request captured; latency down-counter running, access at tc
//   RESP  | resp_valid=1 for one cycle, then back to IDLE
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   req_valid/req_ready   - request handshake
//   req_opcode            - 8 = lw, 9 = sw, anything else faults
//   req_addr              - word address; bits above ADDR_W must be zero
//   req_wdata             - store data
//   resp_valid            - one-cycle response strobe
//   resp_rdata            - load data (0 for sw or fault), held until next response
//   resp_fault            - illegal request, held until next response
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = $clog2(DEPTH),
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  req_opcode,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault
);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q;
   logic [5:0]  opc_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   resp_t       resp_q;

   logic              accept;
   logic              access;
   logic              fault_c;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_idx;
   logic [31:0]       mem_rdata;

   assign req_ready = (state_q == IDLE);
   assign accept    = req_valid && req_ready;
   assign access    = (state_q == BUSY) && (cnt_q == 4'd0);

   assign fault_c = ((addr_q >> ADDR_W) != 32'd0) ||
                    !((opc_q == OPC_LW) || (opc_q == OPC_SW));
   assign mem_we  = access && (opc_q == OPC_SW) && !fault_c;

   // In IDLE the RAM index follows the incoming address so the registered
   // read is already valid one edge after accept; that keeps LATENCY=1 legal.
   assign mem_idx = (state_q == IDLE) ? req_addr[ADDR_W-1:0] : addr_q[ADDR_W-1:0];

   data_mem_array #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .reset (reset),
      .we    (mem_we),
      .idx   (mem_idx),
      .wdata (wdata_q),
      .rdata (mem_rdata)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid) state_d = BUSY;
         BUSY:    if (cnt_q == 4'd0) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         opc_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         resp_q  <= '0;
      end else begin
         state_q      <= state_d;
         resp_q.valid <= access;
         if (accept) begin
            opc_q   <= req_opcode;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= 4'(LATENCY - 1);
         end else if ((state_q == BUSY) && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
         end
         if (access) begin
            resp_q.rdata <= ((opc_q == OPC_LW) && !fault_c) ? mem_rdata : 32'd0;
            resp_q.fault <= fault_c;
         end
      end
   end

   assign resp_valid = resp_q.valid;
   assign resp_rdata = resp_q.rdata;
   assign resp_fault = resp_q.fault;

endmodule
